// File: rtl/pkt_sfifo_if.sv
// Handshake bundle for pkt_sfifo: framed write side toward the link layer and
// a valid/ready read side toward the DMA master.
interface pkt_sfifo_if #(
    parameter int BW     = 32,
    parameter int LGFLEN = 9
);
    logic              i_wr;
    logic [BW-1:0]     i_data;
    logic              i_last;
    logic              i_abort;
    logic              o_full;
    logic [LGFLEN:0]   o_space;
    logic              o_drop;
    logic              o_valid;
    logic              i_ready;
    logic [BW-1:0]     o_data;
    logic              o_last;
    logic [LGFLEN:0]   o_fill;
    logic [LGFLEN:0]   o_pkts;

    modport slave (
        input  i_wr, i_data, i_last, i_abort, i_ready,
        output o_full, o_space, o_drop, o_valid, o_data, o_last, o_fill, o_pkts
    );

    modport master (
        output i_wr, i_data, i_last, i_abort, i_ready,
        input  o_full, o_space, o_drop, o_valid, o_data, o_last, o_fill, o_pkts
    );
endinterface

// File: rtl/pkt_sfifo_mem.sv
// Simple dual-port storage for pkt_sfifo: synchronous write, registered read.
// The read register doubles as the FIFO output register.
module pkt_sfifo_mem #(
    parameter int DW = 33,
    parameter int AW = 9
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_rd,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // NOTE: the array itself is never reset so it stays mappable to block RAM;
    // only the read register is cleared.
    always_ff @(posedge i_clk)
        if (i_wr)
            mem[i_waddr] <= i_wdata;

    always_ff @(posedge i_clk)
        if (i_reset)
            o_rdata <= '0;
        else if (i_rd)
            o_rdata <= mem[i_raddr];
endmodule

// File: rtl/pkt_sfifo.sv
// Packet-aware synchronous FIFO: frames become readable only once their last
// word commits; aborted or overflowed frames roll back without a trace.
module pkt_sfifo #(
    parameter int BW           = 32,
    parameter int LGFLEN       = 9,
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    pkt_sfifo_if.slave  bus
);
    localparam logic [LGFLEN:0] FLEN = {1'b1, {LGFLEN{1'b0}}};

    logic [LGFLEN:0] wr_addr, cm_addr, rd_addr;
    logic [LGFLEN:0] used, commit_len, fill, pkts;
    logic            ovfl, full, drop, valid;
    logic            w_wr, commit, rollback, rd_load, rd_pop;
    logic [BW:0]     rd_word;

    assign used     = wr_addr - rd_addr;
    assign full     = (used == FLEN);
    assign w_wr     = bus.i_wr && !full && !bus.i_abort && !ovfl;
    assign commit   = w_wr && bus.i_last;
    // A last word that could not be stored (full or already overflowed) kills its frame.
    assign rollback = bus.i_abort || (bus.i_wr && bus.i_last && !w_wr);
    assign rd_load  = (!valid || bus.i_ready) && (rd_addr != cm_addr);
    assign rd_pop   = valid && bus.i_ready;
    assign commit_len = commit ? (wr_addr - cm_addr + 1'b1) : '0;

    // NOTE: all state below uses non-blocking assignments so every update
    // sees the pre-edge values of its neighbours.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_addr <= '0;
            cm_addr <= '0;
            rd_addr <= '0;
            ovfl    <= 1'b0;
            drop    <= 1'b0;
            valid   <= 1'b0;
            fill    <= '0;
            pkts    <= '0;
        end else begin
            drop <= rollback;
            if (rollback) begin
                wr_addr <= cm_addr;
                ovfl    <= 1'b0;
            end else begin
                if (w_wr)
                    wr_addr <= wr_addr + 1'b1;
                if (commit)
                    cm_addr <= wr_addr + 1'b1;
                if (bus.i_wr && full)
                    ovfl <= 1'b1;
            end

            if (!valid || bus.i_ready)
                valid <= (rd_addr != cm_addr);
            if (rd_load)
                rd_addr <= rd_addr + 1'b1;

            fill <= fill + commit_len - {{LGFLEN{1'b0}}, rd_pop};
            pkts <= pkts + {{LGFLEN{1'b0}}, commit}
                         - {{LGFLEN{1'b0}}, rd_pop && rd_word[BW]};
        end
    end

    pkt_sfifo_mem #(
        .DW (BW + 1),
        .AW (LGFLEN)
    ) u_mem (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_wr    (w_wr),
        .i_waddr (wr_addr[LGFLEN-1:0]),
        .i_wdata ({bus.i_last, bus.i_data}),
        .i_rd    (rd_load),
        .i_raddr (rd_addr[LGFLEN-1:0]),
        .o_rdata (rd_word)
    );

    assign bus.o_full  = full;
    assign bus.o_space = FLEN - used;
    assign bus.o_drop  = drop;
    assign bus.o_valid = valid;
    assign bus.o_fill  = fill;
    assign bus.o_pkts  = pkts;
    assign bus.o_data  = (OPT_LOWPOWER && !valid) ? '0 : rd_word[BW-1:0];
    assign bus.o_last  = (OPT_LOWPOWER && !valid) ? 1'b0 : rd_word[BW];
endmodule

// File: tb/tb_pkt_sfifo.sv
// Scoreboard bench for pkt_sfifo (LGFLEN=2, low-power outputs): committed
// frames are queued by the driver and checked by an independent output monitor.
module tb_pkt_sfifo;
    localparam int BW     = 16;
    localparam int LGFLEN = 2;
    localparam int FLEN   = 1 << LGFLEN;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pkt_sfifo_if #(.BW(BW), .LGFLEN(LGFLEN)) bus ();

    pkt_sfifo #(
        .BW           (BW),
        .LGFLEN       (LGFLEN),
        .OPT_LOWPOWER (1'b1)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int drop_cnt = 0;
    bit rand_en = 1'b0;

    logic [BW:0] exp_q [$];
    logic [BW:0] cur_q [$];
    logic [BW:0] pend_q [$];
    bit          pend_go = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge; a frame expected to commit on this edge joins the scoreboard now.
    task automatic tick();
        @(posedge clk);
        if (pend_go) begin
            foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
            pend_q.delete();
            pend_go = 1'b0;
        end
        #1;
    endtask

    task automatic wr_word(input logic [BW-1:0] d, input bit last, input bit will_commit);
        bus.i_wr   = 1'b1;
        bus.i_data = d;
        bus.i_last = last;
        cur_q.push_back({last, d});
        if (last) begin
            if (will_commit) begin
                pend_q  = cur_q;
                pend_go = 1'b1;
            end
            cur_q.delete();
        end
        tick();
        bus.i_wr   = 1'b0;
        bus.i_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drain();
        int g;
        g = 0;
        bus.i_ready = 1'b1;
        while (exp_q.size() > 0 && g < 100) begin
            tick();
            g++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    always @(posedge clk)
        if (rand_en) begin
            #1;
            bus.i_ready = 1'($urandom_range(0, 1));
        end

    // Output monitor: occupancy model every cycle, word order on every handshake.
    always @(negedge clk) begin
        int nl;
        if (!rst) begin
            nl = 0;
            foreach (exp_q[i]) if (exp_q[i][BW]) nl++;
            check("fill", 32'(bus.o_fill), exp_q.size());
            check("pkts", 32'(bus.o_pkts), nl);
            if (bus.o_drop) drop_cnt++;
            if (!bus.o_valid)
                check("lowpower_out", {bus.o_last, bus.o_data}, 0);
            else if (bus.i_ready) begin
                if (exp_q.size() == 0)
                    check("unexpected_out", 1, 0);
                else begin
                    check("out_word", {bus.o_last, bus.o_data}, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int d0, g, len;
        bus.i_wr    = 1'b0;
        bus.i_data  = '0;
        bus.i_last  = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_ready = 1'b0;

        // Reset state
        idle(2);
        check("rst_valid", bus.o_valid, 0);
        check("rst_drop",  bus.o_drop, 0);
        check("rst_fill",  bus.o_fill, 0);
        check("rst_pkts",  bus.o_pkts, 0);
        check("rst_full",  bus.o_full, 0);
        check("rst_space", bus.o_space, FLEN);
        check("rst_data",  {bus.o_last, bus.o_data}, 0);
        rst = 1'b0;
        bus.i_ready = 1'b1;

        // 3-word frame, latency and back-to-back read
        wr_word(16'hA000, 1'b0, 1'b1);
        wr_word(16'hA001, 1'b0, 1'b1);
        wr_word(16'hA002, 1'b1, 1'b1);
        check("lat_valid_n", bus.o_valid, 0);
        check("lat_pkts_n",  bus.o_pkts, 1);
        tick();
        check("lat_valid_n1", bus.o_valid, 1);
        check("a0_data", {bus.o_last, bus.o_data}, {1'b0, 16'hA000});
        tick();
        check("a1_data", {bus.o_last, bus.o_data}, {1'b0, 16'hA001});
        tick();
        check("a2_data", {bus.o_last, bus.o_data}, {1'b1, 16'hA002});
        idle(3);
        check("a_pkts_end", bus.o_pkts, 0);
        check("a_valid_end", bus.o_valid, 0);

        // Abort mid-frame, then a one-word frame
        d0 = drop_cnt;
        wr_word(16'hBAD0, 1'b0, 1'b0);
        wr_word(16'hBAD1, 1'b0, 1'b0);
        check("abort_space_pre", bus.o_space, FLEN - 2);
        bus.i_abort = 1'b1;
        cur_q.delete();
        tick();
        bus.i_abort = 1'b0;
        check("abort_drop", bus.o_drop, 1);
        check("abort_space", bus.o_space, FLEN);
        tick();
        check("abort_drop_clr", bus.o_drop, 0);
        wr_word(16'hB000, 1'b1, 1'b1);
        idle(3);
        check("abort_drop_cnt", drop_cnt - d0, 1);
        check("b_space_end", bus.o_space, FLEN);

        // Oversized frame overflows and is dropped; next frame commits
        bus.i_ready = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            wr_word(16'hC000 + 16'(i), i == 5, 1'b0);
            if (i == 3) begin
                check("ovf_full", bus.o_full, 1);
                check("ovf_space0", bus.o_space, 0);
            end
        end
        check("ovf_drop", bus.o_drop, 1);
        check("ovf_full_clr", bus.o_full, 0);
        check("ovf_fill", bus.o_fill, 0);
        check("ovf_space", bus.o_space, FLEN);
        wr_word(16'hD000, 1'b0, 1'b1);
        wr_word(16'hD001, 1'b1, 1'b1);
        idle(2);
        check("d_fill", bus.o_fill, 2);
        check("d_pkts", bus.o_pkts, 1);
        check("d_head", {bus.o_valid, bus.o_last, bus.o_data}, {2'b10, 16'hD000});

        // Commit of E on the same edge as the last word of D leaves
        bus.i_ready = 1'b1;
        tick();
        wr_word(16'hE000, 1'b1, 1'b1);
        check("pkts_simul", bus.o_pkts, 1);
        idle(3);
        check("e_pkts_end", bus.o_pkts, 0);

        // 10 back-to-back frames with random reader stalls
        rand_en = 1'b1;
        for (int f = 0; f < 10; f++) begin
            len = (f % 3) + 1;
            g = 0;
            while (32'(bus.o_space) < len && g < 200) begin
                tick();
                g++;
            end
            if (g >= 200) check("space_timeout", 1, 0);
            for (int w = 0; w < len; w++)
                wr_word(16'h1000 + 16'(f * 16 + w), w == len - 1, 1'b1);
        end
        rand_en = 1'b0;
        tick();
        drain();

        // Reset mid-frame with output valid
        bus.i_ready = 1'b0;
        wr_word(16'hF000, 1'b0, 1'b1);
        wr_word(16'hF001, 1'b1, 1'b1);
        idle(2);
        wr_word(16'h6000, 1'b0, 1'b0);
        check("prerst_valid", bus.o_valid, 1);
        rst = 1'b1;
        tick();
        exp_q.delete();
        cur_q.delete();
        check("mrst_valid", bus.o_valid, 0);
        check("mrst_fill",  bus.o_fill, 0);
        check("mrst_pkts",  bus.o_pkts, 0);
        check("mrst_space", bus.o_space, FLEN);
        check("mrst_drop",  bus.o_drop, 0);
        rst = 1'b0;
        bus.i_ready = 1'b1;
        wr_word(16'h7000, 1'b1, 1'b1);
        drain();
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
